// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared pipeline constants, SRAM wait-state encoding
// and the register-match helper used by the stall logic.
package hazard_stall_unit_pkg;
    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } sramState_t;

    // A pending write to r0 never creates a dependency.
    function automatic logic regMatch(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dest,
                                      input logic wbEn);
        return wbEn && (dest != ZERO_REG) && (src == dest);
    endfunction
endpackage

// File: rtl/hazard_stall_unit_sram_wait_fsm.sv
// sram_wait_fsm: freezes the pipeline for SRAM_WAIT cycles per MEM-stage access,
// then grants one release cycle so the memory instruction can advance.
module sram_wait_fsm
    import hazard_stall_unit_pkg::*;
#(
    parameter int SRAM_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic memReq,
    output logic freeze
);
    localparam int CW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT + 1) : 1;
    localparam logic [CW-1:0] LOAD = CW'((SRAM_WAIT > 0) ? SRAM_WAIT - 1 : 0);

    sramState_t state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic frz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        frz       = 1'b0;
        case (state)
            IDLE: if (memReq && (SRAM_WAIT != 0)) begin
                frz       = 1'b1;
                cntNext   = LOAD;
                stateNext = (SRAM_WAIT == 1) ? RELEASE : WAIT;
            end
            WAIT: begin
                frz       = 1'b1;
                cntNext   = cnt - CW'(1);
                stateNext = (cnt == CW'(1)) ? RELEASE : WAIT;
            end
            default: stateNext = IDLE;
        endcase
        // Freeze must drop the moment reset asserts, even with memReq high in IDLE.
        freeze = frz && rst;
    end
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: detects RAW hazards bypassing cannot resolve, generates the
// SRAM freeze and keeps a saturating stall-cycle counter for debug.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int SRAM_WAIT = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic             stat_clr,
    output logic             hazard,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_count
);
    logic m1e, m2e, m1m, m2m, raw;

    always_comb begin
        m1e = regMatch(src1, exe_dest, exe_wb_en);
        m2e = two_src && regMatch(src2, exe_dest, exe_wb_en);
        m1m = regMatch(src1, mem_dest, mem_wb_en);
        m2m = two_src && regMatch(src2, mem_dest, mem_wb_en);
        // With bypassing only a load in EXE cannot be forwarded in time.
        raw = forward_en ? (exe_mem_r_en && (m1e || m2e)) : (m1e || m2e || m1m || m2m);
        hazard = rst && raw && !freeze;
    end

    sram_wait_fsm #(.SRAM_WAIT(SRAM_WAIT)) uFsm (
        .clk    (clk),
        .rst    (rst),
        .memReq (mem_r_en || mem_w_en),
        .freeze (freeze)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_count <= '0;
        else if (stat_clr)
            stall_count <= '0;
        else if ((hazard || freeze) && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed plus random stimulus against a cycle-level
// reference model; a second SRAM_WAIT=0 instance checks that freezing is disabled.
module tb_hazard_stall_unit;
    localparam int SW = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic forward_en = 0, two_src = 0, exe_wb_en = 0, exe_mem_r_en = 0;
    logic mem_wb_en = 0, mem_r_en = 0, mem_w_en = 0, stat_clr = 0;
    logic [4:0] src1 = 0, src2 = 0, exe_dest = 0, mem_dest = 0;
    logic hazard, freeze, hazard0, freeze0;
    logic [CW-1:0] stall_count;
    logic [15:0] stall_count0;

    int checks = 0;
    int failures = 0;
    int freezeLeft = 0;
    bit inRelease = 0;
    int expCount = 0;
    int expCount0 = 0;
    logic [31:0] frzHist = 0;
    logic [31:0] hazHist = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.SRAM_WAIT(SW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .forward_en(forward_en), .src1(src1), .src2(src2),
        .two_src(two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .stat_clr(stat_clr),
        .hazard(hazard), .freeze(freeze), .stall_count(stall_count)
    );

    hazard_stall_unit #(.SRAM_WAIT(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .forward_en(forward_en), .src1(src1), .src2(src2),
        .two_src(two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .stat_clr(stat_clr),
        .hazard(hazard0), .freeze(freeze0), .stall_count(stall_count0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit expRaw();
        bit m1e, m2e, m1m, m2m;
        m1e = exe_wb_en && exe_dest != 0 && src1 == exe_dest;
        m2e = two_src && exe_wb_en && exe_dest != 0 && src2 == exe_dest;
        m1m = mem_wb_en && mem_dest != 0 && src1 == mem_dest;
        m2m = two_src && mem_wb_en && mem_dest != 0 && src2 == mem_dest;
        return forward_en ? (exe_mem_r_en && (m1e || m2e)) : (m1e || m2e || m1m || m2m);
    endfunction

    // Frozen while wait cycles remain, or when a fresh access shows up outside the release cycle.
    function automatic bit expFreeze();
        if (!rst) return 1'b0;
        return freezeLeft > 0 || (!inRelease && (mem_r_en || mem_w_en));
    endfunction

    task automatic modelReset();
        freezeLeft = 0;
        inRelease  = 0;
        expCount   = 0;
        expCount0  = 0;
    endtask

    task automatic tick(input string tag);
        bit f, h, h0;
        @(negedge clk);
        f  = expFreeze();
        h  = rst && expRaw() && !f;
        h0 = rst && expRaw();
        frzHist = {frzHist[30:0], freeze};
        hazHist = {hazHist[30:0], hazard};
        chk({tag, ".hazard"}, 32'(hazard), 32'(h));
        chk({tag, ".freeze"}, 32'(freeze), 32'(f));
        chk({tag, ".count"}, 32'(stall_count), 32'(expCount));
        chk({tag, ".hazard0"}, 32'(hazard0), 32'(h0));
        chk({tag, ".freeze0"}, 32'(freeze0), 32'(0));
        chk({tag, ".count0"}, 32'(stall_count0), 32'(expCount0));
        @(posedge clk);
        #1;
        if (rst) begin
            expCount  = stat_clr ? 0 : ((h || f) && expCount < (1 << CW) - 1) ? expCount + 1 : expCount;
            expCount0 = stat_clr ? 0 : (h0 && expCount0 < 65535) ? expCount0 + 1 : expCount0;
            if (freezeLeft > 0) begin
                freezeLeft--;
                inRelease = (freezeLeft == 0);
            end else if (inRelease) begin
                inRelease = 0;
            end else if (f) begin
                freezeLeft = SW - 1;
                inRelease  = (SW == 1);
            end
        end
    endtask

    task automatic quiet();
        {forward_en, two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_r_en, mem_w_en, stat_clr} = '0;
        {src1, src2, exe_dest, mem_dest} = '0;
    endtask

    initial begin
        // Reset holds everything low regardless of inputs.
        mem_r_en = 1; exe_wb_en = 1; exe_dest = 3; src1 = 3;
        tick("reset0");
        tick("reset1");
        @(negedge clk);
        rst = 1;
        quiet();
        tick("idle");

        // Load-use with bypassing on.
        forward_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 5; src1 = 5;
        #3 chk("loaduse.direct", 32'(hazard), 32'(1));
        tick("loaduse");
        chk("loaduse.count", 32'(stall_count), 32'(1));
        exe_mem_r_en = 0;
        tick("aluuse");

        // Zero register and immediate operand with bypassing off.
        quiet();
        exe_dest = 0; src1 = 0; exe_wb_en = 1;
        tick("zeroreg");
        quiet();
        mem_dest = 7; src2 = 7; mem_wb_en = 1; src1 = 1; two_src = 0;
        tick("imm");
        two_src = 1;
        tick("twosrc");

        // Single SRAM load: four frozen cycles then release.
        quiet();
        stat_clr = 1;
        tick("clr");
        stat_clr = 0; mem_r_en = 1; frzHist = 0;
        for (int i = 0; i < 5; i++) tick("load");
        chk("load.pattern", frzHist[4:0], 32'b11110);
        mem_r_en = 0;
        chk("load.count", 32'(stall_count), 32'(4));
        tick("load.idle");

        // Back-to-back stores with a masked load-use hazard.
        stat_clr = 1;
        tick("clr2");
        stat_clr = 0; mem_w_en = 1;
        forward_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 3; src1 = 3;
        frzHist = 0; hazHist = 0;
        for (int i = 0; i < 10; i++) tick("b2b");
        chk("b2b.freeze", frzHist[9:0], 32'b1111011110);
        chk("b2b.hazard", hazHist[9:0], 32'b0000100001);
        mem_w_en = 0;

        // Saturation then clear under an active hazard.
        for (int i = 0; i < 20; i++) tick("sat");
        chk("sat.count", 32'(stall_count), 32'(15));
        stat_clr = 1;
        tick("satclr");
        chk("satclr.count", 32'(stall_count), 32'(0));
        stat_clr = 0;

        // Async reset during the second frozen cycle.
        quiet();
        mem_r_en = 1;
        tick("rstwait");
        #2 rst = 0;
        modelReset();
        #1;
        chk("rstwait.freeze", 32'(freeze), 32'(0));
        chk("rstwait.count", 32'(stall_count), 32'(0));
        chk("rstwait.hazard", 32'(hazard), 32'(0));
        tick("inreset");
        @(negedge clk);
        rst = 1; mem_r_en = 0;
        tick("postrst");
        mem_r_en = 1; frzHist = 0;
        for (int i = 0; i < 5; i++) tick("reload");
        chk("reload.pattern", frzHist[4:0], 32'b11110);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            forward_en   = 1'($urandom_range(0, 1));
            two_src      = 1'($urandom_range(0, 1));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_r_en = 1'($urandom_range(0, 1));
            mem_wb_en    = 1'($urandom_range(0, 1));
            mem_r_en     = ($urandom_range(0, 5) == 0);
            mem_w_en     = ($urandom_range(0, 7) == 0);
            stat_clr     = ($urandom_range(0, 30) == 0);
            src1         = 5'($urandom_range(0, 3));
            src2         = 5'($urandom_range(0, 3));
            exe_dest     = 5'($urandom_range(0, 3));
            mem_dest     = 5'($urandom_range(0, 3));
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall-side counterpart to the operand forwarding path in the 5-stage MIPS-style pipeline.
- Detects hazards that bypassing cannot resolve and drives the pipeline controls:
  - `hazard`: hold IF/ID, inject a bubble into ID/EXE.
  - `freeze`: hold every pipeline register while a MEM-stage SRAM access completes its wait states.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- SRAM_WAIT, 4, freeze cycles per MEM-stage load/store; 0 disables freezing.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous, active-low reset.
- forward_en  input  1  1 = bypass network active; 0 = stall on every RAW hazard.
- src1  input  5  ID-stage source register 1.
- src2  input  5  ID-stage source register 2.
- two_src  input  1  ID instruction reads src2 as a register (not immediate; store data counts).
- exe_dest  input  5  EXE-stage destination register.
- exe_wb_en  input  1  EXE-stage writeback enable.
- exe_mem_r_en  input  1  EXE-stage instruction is a load.
- mem_dest  input  5  MEM-stage destination register.
- mem_wb_en  input  1  MEM-stage writeback enable.
- mem_r_en  input  1  MEM-stage load.
- mem_w_en  input  1  MEM-stage store.
- stat_clr  input  1  synchronous clear of stall_count.
- hazard  output  1  stall IF/ID, bubble ID/EXE.
- freeze  output  1  hold all pipeline registers.
- stall_count  output  CNT_W  saturating count of cycles with hazard|freeze.

Behaviour:
- Reset (rst=0, async): state=IDLE, wait counter=0, stall_count=0, freeze=0, hazard=0 regardless of inputs.

Match terms (combinational):
- m1e = (src1==exe_dest) & exe_wb_en & (exe_dest!=0).
- m2e = two_src & (src2==exe_dest) & exe_wb_en & (exe_dest!=0).
- m1m and m2m: same as m1e and m2e, using mem_dest and mem_wb_en.

Raw hazard:
- forward_en=1: raw = exe_mem_r_en & (m1e|m2e). Load-use only; the MEM stage is always bypassable.
- forward_en=0: raw = m1e|m2e|m1m|m2m.

Outputs:
- hazard = raw & ~freeze. No hazard is reported while frozen, so each stall cycle has exactly one cause.
- mem_req = mem_r_en|mem_w_en.

SRAM FSM (states IDLE, WAIT, RELEASE):
- IDLE:
  - freeze = mem_req & (SRAM_WAIT!=0).
  - If freeze: cnt <= SRAM_WAIT-1; next = RELEASE if SRAM_WAIT==1, else WAIT.
- WAIT:
  - freeze=1; cnt <= cnt-1.
  - When cnt==1: next=RELEASE.
- RELEASE:
  - freeze=0; the memory instruction advances.
  - mem_req is ignored this cycle; next=IDLE.
- Result: exactly SRAM_WAIT frozen cycles, then one release cycle.
- Back-to-back memory instructions:
  - The second reaches MEM in the cycle after RELEASE and re-enters the sequence from IDLE.
  - Minimum spacing between freeze windows is 1 unfrozen cycle.
- SRAM_WAIT=0: FSM never leaves IDLE; freeze constant 0.
- Async reset mid-WAIT: returns to IDLE immediately, freeze drops in the same cycle. The pipeline is reset concurrently.

stall_count:
- On each rising edge: if stat_clr, load 0.
- Else if hazard|freeze, increment, saturating at 2^CNT_W-1.
- stat_clr has priority over increment.
- Latency: hazard is combinational (same cycle); freeze is combinational in IDLE and registered-state-driven afterwards.

Decomposition:
- Shared pipeline package:
  - Register-index width (5).
  - Zero register constant (5'd0).
  - FSM state encoding for IDLE/WAIT/RELEASE (2 bits).
- One natural sub-module: `sram_wait_fsm`, containing the state register, the wait counter and freeze generation.
- RAW comparison and stall_count stay in the top level.

Test Plan:
- Load-use, forward_en=1: exe_mem_r_en=1, exe_wb_en=1, exe_dest=5, src1=5, no MEM access -> hazard=1 that cycle; stall_count +1. Same with exe_mem_r_en=0 -> hazard=0.
- Zero register and immediate, forward_en=0:
  - exe_dest=0, src1=0, exe_wb_en=1 -> hazard=0.
  - mem_dest=7, src2=7, two_src=0 -> hazard=0.
  - two_src=1 -> hazard=1.
- SRAM freeze, SRAM_WAIT=4: mem_r_en held 1 -> freeze=1 for exactly 4 cycles, 0 in the 5th (RELEASE); stall_count=4.
- Back-to-back stores: mem_w_en high continuously -> freeze pattern 1111 0 1111 0; simultaneous load-use hazard is masked (hazard=0) during freeze and asserts in the RELEASE cycle.
- Saturation and clear, CNT_W=4: 20 stall cycles -> stall_count=15. stat_clr pulsed while hazard=1 -> stall_count=0 on the next edge.
- Reset mid-WAIT: rst low at the 2nd frozen cycle -> freeze=0 and stall_count=0 immediately. After release, a new mem_r_en gives a full 4-cycle freeze.
